regfile_wr_arbiter: RTL

- Owns the single write port of the 32x64 register file (X31 hardwired to zero).
- After reset, runs an init sequence that clears X0..X30 to INIT_VAL.
- Then shares the write port between two writeback requesters, A (ALU) and B (load/memory), using valid/ready handshakes and round-robin arbitration.
- Drives writeReg/writeData/regWrEn directly into the regfile from registers.

---
 rtl/regfile_wr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 32x64 register file: clears X0..X(NUM_REGS-2) after reset,
// then round-robin arbitrates ALU (A) and load (B) writebacks onto one registered write port.
module regfile_wr_arbiter #(
  parameter int                DATA_W   = 64,
  parameter int                ADDR_W   = 5,
  parameter int                NUM_REGS = 32,
  parameter int                ZERO_REG = 31,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrEn,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef enum logic {GNT_A, GNT_B} side_e;

  localparam logic [ADDR_W-1:0] LAST_INIT_IDX = ADDR_W'(NUM_REGS - 2);
  localparam logic [ADDR_W-1:0] ZERO_IDX      = ADDR_W'(ZERO_REG);

  state_e              state_q, state_d;
  side_e               last_q, last_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                init_done_q, init_done_d;
  logic                grant_a, grant_b;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    init_done_d = init_done_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q <= LAST_INIT_IDX) begin
          wr_reg_d  = cnt_q;
          wr_data_d = INIT_VAL;
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end

      ST_RUN: begin
        // A wins contention only when B was served last, giving A,B,A,B under load.
        grant_a = a_valid && (!b_valid || (last_q == GNT_B));
        grant_b = b_valid && !grant_a;
        if (grant_a) begin
          last_d    = GNT_A;
          wr_reg_d  = a_reg;
          wr_data_d = a_data;
          wr_en_d   = (a_reg != ZERO_IDX);
        end else if (grant_b) begin
          last_d    = GNT_B;
          wr_reg_d  = b_reg;
          wr_data_d = b_data;
          wr_en_d   = (b_reg != ZERO_IDX);
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      last_q      <= GNT_B;
      cnt_q       <= '0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      init_done_q <= init_done_d;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign writeReg  = wr_reg_q;
  assign writeData = wr_data_q;
  assign regWrEn   = wr_en_q;
  assign init_done = init_done_q;

endmodule
